// File: rtl/pinfilter_pkg.sv
// Shared definitions for the pinfilter_bus debounce/deglitch filter.
// Holds default parameters, the per-channel decision type and the counter-width helper.
package pinfilter_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_STABLE_CNT  = 2;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_GLITCH_W    = 8;

  // What a channel does with the current sample; also a convenient probe point.
  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_COUNT  = 2'd1,
    CH_ACCEPT = 2'd2,
    CH_ABORT  = 2'd3
  } ch_action_e;

  // Counter must hold values 0..STABLE_CNT-1 plus headroom for the increment compare.
  function automatic int cnt_w(input int stable_cnt);
    if (stable_cnt < 1) return 1;
    return $clog2(stable_cnt + 1);
  endfunction

endpackage

// File: rtl/pinfilter_ch.sv
// One filter channel: synchroniser chain, disagreement counter, filtered level,
// registered edge pulses and a combinational abort (glitch) flag.
module pinfilter_ch
  import pinfilter_pkg::*;
#(
  parameter int   STABLE_CNT  = DEF_STABLE_CNT,
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic RESET_BIT   = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  input  logic ena,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic settled,
  output logic glitch
);

  localparam int             CNT_W     = cnt_w(STABLE_CNT);
  localparam logic [CNT_W:0] LP_STABLE = (CNT_W + 1)'(STABLE_CNT);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_dout;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;
  logic [CNT_W:0]         w_cnt_inc;
  ch_action_e             w_action;

  // The synchroniser runs every clock; ena only gates the filter decision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {SYNC_STAGES{RESET_BIT}};
    end else begin
      r_sync[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W + 1)'(1);

  always_comb begin
    w_action = CH_IDLE;
    if (ena) begin
      if (w_s != r_dout) begin
        w_action = (w_cnt_inc == LP_STABLE) ? CH_ACCEPT : CH_COUNT;
      end else if (r_cnt != '0) begin
        w_action = CH_ABORT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout <= RESET_BIT;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (w_action)
        CH_COUNT: r_cnt <= w_cnt_inc[CNT_W-1:0];
        CH_ACCEPT: begin
          r_dout <= w_s;
          r_cnt  <= '0;
          r_rise <= w_s;
          r_fall <= ~w_s;
        end
        CH_ABORT: r_cnt <= '0;
        default: ;
      endcase
    end
  end

  assign dout    = r_dout;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign settled = (r_cnt == '0);
  assign glitch  = (w_action == CH_ABORT);

endmodule

// File: rtl/pinfilter_bus.sv
// Multi-channel GPIO debounce/deglitch filter with edge pulses, settling flags
// and a saturating count of clocks in which any channel aborted a transition.
module pinfilter_bus
  import pinfilter_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter int               STABLE_CNT  = DEF_STABLE_CNT,
  parameter int               SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL   = '1,
  parameter int               GLITCH_W    = DEF_GLITCH_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    din,
  input  logic                ena,
  output logic [WIDTH-1:0]    dout,
  output logic [WIDTH-1:0]    rise,
  output logic [WIDTH-1:0]    fall,
  output logic [WIDTH-1:0]    settled,
  input  logic                glitch_clr,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  logic [WIDTH-1:0]    w_glitch;
  logic [GLITCH_W-1:0] r_glitch_cnt;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    pinfilter_ch #(
      .STABLE_CNT (STABLE_CNT),
      .SYNC_STAGES(SYNC_STAGES),
      .RESET_BIT  (RESET_VAL[g])
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (din[g]),
      .ena    (ena),
      .dout   (dout[g]),
      .rise   (rise[g]),
      .fall   (fall[g]),
      .settled(settled[g]),
      .glitch (w_glitch[g])
    );
  end

  // Counts clocks with at least one abort, not the number of aborting channels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_glitch_cnt <= '0;
    end else if (glitch_clr) begin
      r_glitch_cnt <= '0;
    end else if ((|w_glitch) && (r_glitch_cnt != '1)) begin
      r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
    end
  end

  assign glitch_cnt = r_glitch_cnt;

endmodule
